// File: rtl/machine_press_solver.sv
// machine_press_solver: collects one line of light/button wiring words while
// the previous line is searched, then walks every button subset in Gray-code
// order to find the fewest presses whose XOR equals the line's target.
module machine_press_solver #(
  parameter int MAX_WIRING_WIDTH = 16,
  parameter int MAX_BUTTONS      = 16,
  parameter int PRESS_WIDTH      = $clog2(MAX_BUTTONS + 1),
  parameter int SUM_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        end_of_file,
  input  logic                        end_of_line,
  input  logic                        wiring_valid,
  input  logic [MAX_WIRING_WIDTH-1:0] wiring_data,
  output logic                        line_valid,
  output logic [PRESS_WIDTH-1:0]      line_presses,
  output logic                        line_unsolvable,
  output logic                        sum_valid,
  output logic [SUM_WIDTH-1:0]        sum_presses,
  output logic                        overflow
);

  localparam int IDX_W  = (MAX_BUTTONS > 1) ? $clog2(MAX_BUTTONS) : 1;
  localparam int K_W    = MAX_BUTTONS + 1;
  // best carries a spare bit so its all-ones "nothing found" value can never
  // collide with a real press count
  localparam int BEST_W = PRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, REPORT} state_t;

  state_t                      state;

  // collect bank (line being received)
  logic [MAX_WIRING_WIDTH-1:0] col_target;
  logic                        col_has_target;
  logic [PRESS_WIDTH-1:0]      col_n;
  logic [MAX_WIRING_WIDTH-1:0] col_btn [MAX_BUTTONS];

  // collect bank after this cycle's word is applied
  logic [MAX_WIRING_WIDTH-1:0] col_target_nx;
  logic                        col_has_nx;
  logic [PRESS_WIDTH-1:0]      col_n_nx;
  logic [MAX_WIRING_WIDTH-1:0] col_btn_nx [MAX_BUTTONS];

  // search bank (line being solved)
  logic [MAX_WIRING_WIDTH-1:0] srch_target;
  logic [PRESS_WIDTH-1:0]      srch_n;
  logic [MAX_WIRING_WIDTH-1:0] srch_btn [MAX_BUTTONS];

  logic                        pending;
  logic                        drop_active;
  logic                        drop_nx;
  logic                        drop_mode;
  logic                        ovf_set;
  logic                        commit;
  logic                        accept_now;
  logic                        pend_set;
  logic                        copy_pending;

  logic [K_W-1:0]              k;
  logic [K_W-1:0]              k_last;
  logic [MAX_WIRING_WIDTH-1:0] acc;
  logic [MAX_WIRING_WIDTH-1:0] acc_nx;
  logic [BEST_W-1:0]           best;
  logic [BEST_W-1:0]           gray_p;
  logic [IDX_W-1:0]            j;

  // index of the lowest set bit: the button toggled at Gray step k
  function automatic logic [IDX_W-1:0] ctz(input logic [K_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = MAX_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // number of buttons pressed in a Gray-code subset
  function automatic logic [BEST_W-1:0] popcnt(input logic [K_W-1:0] v);
    logic [BEST_W-1:0] c;
    c = '0;
    for (int i = 0; i < K_W; i++) begin
      c = c + BEST_W'(v[i]);
    end
    return c;
  endfunction

  // A line whose words arrive while the previous line is still waiting is
  // dropped in full, including any words that trail past the pending copy.
  assign drop_mode    = pending || drop_active;
  assign commit       = end_of_line && !drop_mode && col_has_nx;
  assign accept_now   = commit && ((state == IDLE) || (state == REPORT));
  assign pend_set     = commit && !accept_now;
  assign copy_pending = (state == REPORT) && pending;
  assign k_last       = (K_W'(1) << srch_n) - K_W'(1);

  // Apply this cycle's wiring word to the collect bank; word precedes commit
  always_comb begin
    col_target_nx = col_target;
    col_has_nx    = col_has_target;
    col_n_nx      = col_n;
    col_btn_nx    = col_btn;
    drop_nx       = drop_active;
    ovf_set       = 1'b0;
    if (drop_mode) begin
      if (wiring_valid) begin
        ovf_set = 1'b1;
        drop_nx = 1'b1;
      end
      if (end_of_line) drop_nx = 1'b0;
    end else if (wiring_valid) begin
      if (!col_has_target) begin
        col_target_nx = wiring_data;
        col_has_nx    = 1'b1;
      end else if (col_n < PRESS_WIDTH'(MAX_BUTTONS)) begin
        col_btn_nx[col_n[IDX_W-1:0]] = wiring_data;
        col_n_nx                     = col_n + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
    // an unterminated line at end of file is thrown away
    if (end_of_file && !end_of_line && !pending) begin
      col_has_nx = 1'b0;
      col_n_nx   = '0;
    end
  end

  // Next Gray step: toggled button, accumulated XOR, subset size
  always_comb begin
    j      = ctz(k);
    acc_nx = acc ^ srch_btn[j];
    gray_p = popcnt(k ^ (k >> 1));
  end

  // Collect/search bank registers, pending handoff and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      col_target     <= '0;
      col_has_target <= 1'b0;
      col_n          <= '0;
      srch_target    <= '0;
      srch_n         <= '0;
      for (int i = 0; i < MAX_BUTTONS; i++) begin
        col_btn[i]  <= '0;
        srch_btn[i] <= '0;
      end
      pending     <= 1'b0;
      drop_active <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      drop_active <= drop_nx;
      if (ovf_set) overflow <= 1'b1;
      col_btn    <= col_btn_nx;
      col_target <= col_target_nx;
      if (copy_pending) begin
        srch_target    <= col_target;
        srch_n         <= col_n;
        srch_btn       <= col_btn;
        col_has_target <= 1'b0;
        col_n          <= '0;
        pending        <= 1'b0;
      end else if (accept_now) begin
        srch_target    <= col_target_nx;
        srch_n         <= col_n_nx;
        srch_btn       <= col_btn_nx;
        col_has_target <= 1'b0;
        col_n          <= '0;
      end else begin
        col_has_target <= col_has_nx;
        col_n          <= col_n_nx;
        if (pend_set) pending <= 1'b1;
      end
    end
  end

  // Search sequencer with registered per-line and total results
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      k               <= '0;
      acc             <= '0;
      best            <= '0;
      line_valid      <= 1'b0;
      line_presses    <= '0;
      line_unsolvable <= 1'b0;
      sum_valid       <= 1'b0;
      sum_presses     <= '0;
    end else begin
      line_valid <= 1'b0;
      if (end_of_file && (state == IDLE) && !pending && !col_has_target && !end_of_line)
        sum_valid <= 1'b1;
      case (state)
        IDLE: begin
          if (accept_now) state <= LOAD;
        end
        LOAD: begin
          acc  <= '0;
          best <= '1;
          k    <= K_W'(1);
          if (srch_target == '0) begin
            best  <= '0;
            state <= REPORT;
          end else if (srch_n == '0) begin
            state <= REPORT;
          end else begin
            state <= SEARCH;
          end
        end
        SEARCH: begin
          acc <= acc_nx;
          if ((acc_nx == srch_target) && (gray_p < best)) best <= gray_p;
          if (k == k_last) state <= REPORT;
          else             k     <= k + 1'b1;
        end
        REPORT: begin
          line_valid <= 1'b1;
          if (best == '1) begin
            line_presses    <= '0;
            line_unsolvable <= 1'b1;
          end else begin
            line_presses    <= best[PRESS_WIDTH-1:0];
            line_unsolvable <= 1'b0;
            sum_presses     <= sum_presses + SUM_WIDTH'(best);
          end
          if (pending || accept_now) state <= LOAD;
          else                       state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_press_solver.sv
// tb_machine_press_solver: directed vectors with hand-computed press counts,
// latencies and running sums for the machine press solver.
module tb_machine_press_solver;
  localparam int W  = 16;
  localparam int NB = 16;
  localparam int PW = 5;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          end_of_file;
  logic          end_of_line;
  logic          wiring_valid;
  logic [W-1:0]  wiring_data;
  logic          line_valid;
  logic [PW-1:0] line_presses;
  logic          line_unsolvable;
  logic          sum_valid;
  logic [SW-1:0] sum_presses;
  logic          overflow;

  always #5 clk = ~clk;

  machine_press_solver #(
    .MAX_WIRING_WIDTH(W),
    .MAX_BUTTONS(NB),
    .PRESS_WIDTH(PW),
    .SUM_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .end_of_file(end_of_file),
    .end_of_line(end_of_line),
    .wiring_valid(wiring_valid),
    .wiring_data(wiring_data),
    .line_valid(line_valid),
    .line_presses(line_presses),
    .line_unsolvable(line_unsolvable),
    .sum_valid(sum_valid),
    .sum_presses(sum_presses),
    .overflow(overflow)
  );

  typedef struct {
    int cyc;
    int presses;
    int unsolv;
    int sum;
  } rpt_t;

  rpt_t         q[$];
  logic [W-1:0] bq[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  int           eol_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // record every reported line with the edge count at which it appeared
  always @(posedge clk) begin
    #1;
    if (line_valid)
      q.push_back('{cyc, int'(line_presses), int'(line_unsolvable), int'(sum_presses)});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    wiring_valid = 1'b1;
    wiring_data  = w;
    tick();
    wiring_valid = 1'b0;
    wiring_data  = '0;
  endtask

  task automatic send_eol();
    end_of_line = 1'b1;
    eol_cyc     = cyc;
    tick();
    end_of_line = 1'b0;
  endtask

  task automatic send_line(input logic [W-1:0] tgt);
    send_word(tgt);
    foreach (bq[i]) send_word(bq[i]);
    send_eol();
  endtask

  task automatic wait_lines(input int cnt, input int budget);
    int b;
    b = 0;
    while (q.size() < cnt && b < budget) begin
      tick();
      b++;
    end
  endtask

  task automatic expect_line(input string tag, input int p, input int u, input int s, input int lat);
    rpt_t r;
    wait_lines(1, lat + 40);
    check({tag, " seen"}, q.size(), 1);
    if (q.size() > 0) begin
      r = q.pop_front();
      check({tag, " presses"}, r.presses, p);
      check({tag, " unsolvable"}, r.unsolv, u);
      check({tag, " sum"}, r.sum, s);
      check({tag, " latency"}, r.cyc - eol_cyc, lat);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic load_example1();
    bq = '{16'h0008, 16'h000A, 16'h0004, 16'h000C, 16'h0005, 16'h0003};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rpt_t r1;
    rpt_t r2;
    int   e1;
    int   b;
    rst = 1'b1;
    end_of_file  = 1'b0;
    end_of_line  = 1'b0;
    wiring_valid = 1'b0;
    wiring_data  = '0;
    repeat (3) tick();
    check("rst line_valid", line_valid, 0);
    check("rst line_presses", line_presses, 0);
    check("rst unsolvable", line_unsolvable, 0);
    check("rst sum_valid", sum_valid, 0);
    check("rst sum", sum_presses, 0);
    check("rst overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // first example line: 0xA ^ 0xC reaches 0x6 in two presses
    load_example1();
    send_line(16'h0006);
    expect_line("ex1", 2, 0, 2, 66);
    check("ex1 overflow", overflow, 0);

    // zero target needs no presses and skips the search
    bq = '{16'h0001, 16'h0002, 16'h0004};
    send_line(16'h0000);
    expect_line("zero", 0, 0, 2, 3);

    // single button cannot reach the target
    bq = '{16'h0002};
    send_line(16'h0001);
    expect_line("unsolv", 0, 1, 2, 4);

    // three 10-button lines back to back: second waits, third is dropped
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(16'h0001 << i);
    send_line(16'h000F);
    e1 = eol_cyc;
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(16'h0003 << i);
    send_line(16'h0401);
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(16'h0001 << i);
    send_line(16'h03FF);
    wait_lines(2, 2300);
    check("bb seen", q.size(), 2);
    if (q.size() >= 2) begin
      r1 = q[0];
      r2 = q[1];
      check("bb l1 presses", r1.presses, 4);
      check("bb l1 latency", r1.cyc - e1, 1026);
      check("bb l2 presses", r2.presses, 10);
      check("bb l2 gap", r2.cyc - r1.cyc, 1025);
      check("bb l2 sum", r2.sum, 16);
    end
    q.delete();
    repeat (1100) tick();
    check("bb third dropped", q.size(), 0);
    check("bb overflow", overflow, 1);

    // reset in the middle of a search
    send_line(16'h00FF);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    tick();
    check("mid rst line_valid", line_valid, 0);
    check("mid rst presses", line_presses, 0);
    check("mid rst unsolvable", line_unsolvable, 0);
    check("mid rst sum_valid", sum_valid, 0);
    check("mid rst sum", sum_presses, 0);
    check("mid rst overflow", overflow, 0);
    rst = 1'b0;
    q.delete();
    repeat (1100) tick();
    check("mid rst no report", q.size(), 0);
    load_example1();
    send_line(16'h0006);
    expect_line("post rst", 2, 0, 2, 66);

    // full three-line example, a stray partial line, then end of file
    do_reset();
    load_example1();
    send_line(16'h0006);
    expect_line("aoc1", 2, 0, 2, 66);
    bq = '{16'h001D, 16'h000C, 16'h0011, 16'h0007, 16'h001E};
    send_line(16'h0008);
    expect_line("aoc2", 3, 0, 5, 34);
    bq = '{16'h001F, 16'h0019, 16'h0037, 16'h0006};
    send_line(16'h002E);
    expect_line("aoc3", 2, 0, 7, 18);
    check("pre eof sum_valid", sum_valid, 0);
    send_word(16'h0005);
    end_of_file = 1'b1;
    b = 0;
    while (!sum_valid && b < 20) begin
      tick();
      b++;
    end
    check("eof sum_valid", sum_valid, 1);
    check("eof sum", sum_presses, 7);
    repeat (5) tick();
    check("eof partial dropped", q.size(), 0);
    check("eof sum_valid held", sum_valid, 1);
    end_of_file = 1'b0;

    // seventeenth button exceeds the bank and is dropped
    do_reset();
    bq.delete();
    for (int i = 1; i <= 17; i++) bq.push_back(16'(i));
    send_line(16'h0000);
    expect_line("17btn", 0, 0, 0, 3);
    check("17btn overflow", overflow, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
